// File: rtl/qdi_pkg.sv
// Shared definitions for the e1of3 QDI receiver: rail codes, FSM states
// and small rail-code helpers.
package qdi_pkg;

    localparam logic [2:0] E1OF3_0 = 3'b001;
    localparam logic [2:0] E1OF3_1 = 3'b010;
    localparam logic [2:0] E1OF3_2 = 3'b100;
    localparam logic [2:0] E1OF3_N = 3'b000;

    typedef enum logic [1:0] {
        WAIT_DATA,
        WAIT_NEUTRAL,
        STALL
    } rx_state_t;

    // Map a one-hot rail code to its 2-bit value; anything else reads as 0.
    function automatic logic [1:0] e1of3_decode(input logic [2:0] code);
        logic [1:0] val;
        val = 2'd0;
        case (code)
            E1OF3_0: val = 2'd0;
            E1OF3_1: val = 2'd1;
            E1OF3_2: val = 2'd2;
            default: val = 2'd0;
        endcase
        return val;
    endfunction

    function automatic logic is_onehot(input logic [2:0] code);
        return (code == E1OF3_0) || (code == E1OF3_1) || (code == E1OF3_2);
    endfunction

    function automatic logic is_neutral(input logic [2:0] code);
        return code == E1OF3_N;
    endfunction

endpackage

// File: rtl/qdi_sync_fifo.sv
// Show-ahead synchronous FIFO. The head word is visible on rdata whenever
// the FIFO is non-empty; rdata reads as zero when empty so no stale or
// uninitialised storage is ever presented.
module qdi_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == FULL_CNT);
    assign count   = count_reg;
    assign pop_ok  = pop && !empty;
    assign push_ok = push && !full;
    assign rdata   = empty ? '0 : mem[rd_ptr_reg];

    // Storage write; no reset so the array can map onto RAM resources.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/qdi_1of3_to_bin.sv
// Clocked receiver terminating an e1of3 QDI channel: synchronizes the rails,
// runs the 4-phase enable handshake, and buffers decoded words in a FIFO.
// Multi-hot codes raise a sticky error and are otherwise dropped.
module qdi_1of3_to_bin
    import qdi_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [2:0] L,
    output logic       Le,
    output logic [1:0] dout,
    output logic       dvalid,
    input  logic       dready,
    output logic       err,
    inout  wire        VDD,
    inout  wire        GND
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [SYNC_STAGES-1:0][2:0] sync_reg;
    logic [SYNC_STAGES-1:0]      warm_reg;
    rx_state_t                   state_reg;
    logic                        le_reg;
    logic                        err_reg;

    logic [2:0]    s_code;
    logic [2:0]    s_newer;
    logic          stable;
    logic          push;
    logic          pop;
    logic [1:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          has_room;

    // Supply pins are carried for netlist compatibility only.
    wire unused_pins = ^{VDD, GND, fifo_full};

    // Rail synchronizer chain; index 0 samples the asynchronous rails.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], L};
        end
    end

    // Warm-up: the chain is only trusted once it has refilled after reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            warm_reg <= '0;
        end else begin
            warm_reg <= {warm_reg[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // The last two stages hold the same code one cycle apart, so agreement
    // means the code has held for a full cycle; single-cycle glitches never
    // appear in both stages at once.
    assign s_code   = sync_reg[SYNC_STAGES-1];
    assign s_newer  = sync_reg[SYNC_STAGES-2];
    assign stable   = warm_reg[SYNC_STAGES-1] && (s_code == s_newer);
    assign has_room = (fifo_count < DEPTH_CNT);

    // Le only rises with a free slot, so a push never meets a full FIFO.
    assign push = (state_reg == WAIT_DATA) && stable && is_onehot(s_code);
    assign pop  = dready && !fifo_empty;

    // Handshake FSM with registered Le and sticky error flag.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg <= WAIT_NEUTRAL;
            le_reg    <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                WAIT_DATA: begin
                    if (stable && !is_neutral(s_code)) begin
                        if (!is_onehot(s_code)) begin
                            err_reg <= 1'b1;
                        end
                        state_reg <= WAIT_NEUTRAL;
                        le_reg    <= 1'b0;
                    end
                end
                WAIT_NEUTRAL: begin
                    if (stable && is_neutral(s_code)) begin
                        if (has_room) begin
                            state_reg <= WAIT_DATA;
                            le_reg    <= 1'b1;
                        end else begin
                            state_reg <= STALL;
                        end
                    end
                end
                STALL: begin
                    if (has_room || pop) begin
                        state_reg <= WAIT_DATA;
                        le_reg    <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= WAIT_NEUTRAL;
                    le_reg    <= 1'b0;
                end
            endcase
        end
    end

    qdi_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (push),
        .wdata (e1of3_decode(s_code)),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign Le     = le_reg;
    assign err    = err_reg;
    assign dout   = fifo_rdata;
    assign dvalid = !fifo_empty;

endmodule

// File: tb/tb_qdi_1of3_to_bin.sv
// Directed bench for qdi_1of3_to_bin (DEPTH=4, SYNC_STAGES=2): exact reset
// and token latencies, back-to-back streaming, FIFO stall, multi-hot error,
// glitch rejection and mid-handshake reset.
module tb_qdi_1of3_to_bin;

    typedef struct {
        logic [2:0] rails;
        int         hold;
        logic       push;
        logic [1:0] word;
        logic       err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] rails = 3'b000;
    logic       dready = 1'b0;
    wire        le;
    wire  [1:0] dout;
    wire        dvalid;
    wire        err;
    wire        vdd;
    wire        gnd;

    assign vdd = 1'b1;
    assign gnd = 1'b0;

    int tests = 0;
    int fails = 0;
    int le_falls = 0;
    logic le_prev = 1'b0;
    int popq[$];

    qdi_1of3_to_bin #(
        .DEPTH       (4),
        .SYNC_STAGES (2)
    ) dut (
        .CLK    (clk),
        .RESET  (rst),
        .L      (rails),
        .Le     (le),
        .dout   (dout),
        .dvalid (dvalid),
        .dready (dready),
        .err    (err),
        .VDD    (vdd),
        .GND    (gnd)
    );

    always #5 clk = ~clk;

    // Count Le falling edges and record every word the consumer takes.
    always @(negedge clk) begin
        if (le_prev && !le) le_falls <= le_falls + 1;
        le_prev <= le;
        if (dvalid === 1'b1 && dready === 1'b1) popq.push_back(int'(dout));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("[TB] ok %s: %0d", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bounded wait for Le to reach v; the final value is always compared.
    task automatic wait_le(input logic v, input string name);
        int n;
        n = 0;
        while (le !== v && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(le), 32'(v));
    endtask

    // One 4-phase transfer; returns with rails back to neutral.
    task automatic handshake(input logic [2:0] r, input int hold, input string name);
        wait_le(1'b1, {name, "_le_hi"});
        rails = r;
        wait_le(1'b0, {name, "_le_lo"});
        tick(hold);
        rails = 3'b000;
    endtask

    vec_t vecs[8];
    int   q0;
    int   f0;
    int   exp_seq[4];
    int   exp_left[4];

    initial begin
        vecs[0] = '{rails: 3'b001, hold: 0, push: 1'b1, word: 2'd0, err: 1'b0};
        vecs[1] = '{rails: 3'b010, hold: 0, push: 1'b1, word: 2'd1, err: 1'b0};
        vecs[2] = '{rails: 3'b100, hold: 1, push: 1'b1, word: 2'd2, err: 1'b0};
        vecs[3] = '{rails: 3'b001, hold: 2, push: 1'b1, word: 2'd0, err: 1'b0};
        vecs[4] = '{rails: 3'b011, hold: 3, push: 1'b0, word: 2'd0, err: 1'b1};
        vecs[5] = '{rails: 3'b100, hold: 0, push: 1'b1, word: 2'd2, err: 1'b1};
        vecs[6] = '{rails: 3'b111, hold: 1, push: 1'b0, word: 2'd0, err: 1'b1};
        vecs[7] = '{rails: 3'b010, hold: 0, push: 1'b1, word: 2'd1, err: 1'b1};
        exp_seq  = '{0, 1, 2, 0};
        exp_left = '{1, 2, 1, 2};

        // Reset values and Le rising after the third edge.
        #2;
        check("rst_le", 32'(le), 0);
        check("rst_dvalid", 32'(dvalid), 0);
        check("rst_err", 32'(err), 0);
        check("rst_dout", 32'(dout), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); check("rst_le_edge1", 32'(le), 0);
        @(negedge clk); check("rst_le_edge2", 32'(le), 0);
        @(negedge clk); check("rst_le_edge3", 32'(le), 1);

        // Single token with exact latency: push and Le fall at edge N+2.
        rails = 3'b010;
        @(negedge clk);
        check("tok_le_N", 32'(le), 1);
        check("tok_dvalid_N", 32'(dvalid), 0);
        @(negedge clk);
        check("tok_le_N1", 32'(le), 1);
        check("tok_dvalid_N1", 32'(dvalid), 0);
        @(negedge clk);
        check("tok_le_N2", 32'(le), 0);
        check("tok_dvalid_N2", 32'(dvalid), 1);
        check("tok_dout_N2", 32'(dout), 1);
        rails = 3'b000;
        @(negedge clk); check("rel_le_M", 32'(le), 0);
        @(negedge clk); check("rel_le_M1", 32'(le), 0);
        @(negedge clk); check("rel_le_M2", 32'(le), 1);
        check("tok_err", 32'(err), 0);
        dready = 1'b1;
        @(negedge clk);
        dready = 1'b0;
        check("tok_popped", 32'(dvalid), 0);

        // Back-to-back stream with the consumer always ready.
        dready = 1'b1;
        q0 = popq.size();
        f0 = le_falls;
        handshake(3'b001, 0, "b2b0");
        handshake(3'b010, 0, "b2b1");
        handshake(3'b100, 0, "b2b2");
        handshake(3'b001, 0, "b2b3");
        wait_le(1'b1, "b2b_end_le");
        tick(2);
        dready = 1'b0;
        check("b2b_count", 32'(popq.size() - q0), 4);
        for (int i = 0; i < 4; i++) begin
            if (q0 + i < popq.size())
                check($sformatf("b2b_word%0d", i), 32'(popq[q0 + i]), 32'(exp_seq[i]));
        end
        check("b2b_le_falls", 32'(le_falls - f0), 4);

        // Fill the FIFO, stall the fifth token, release with one pop.
        handshake(3'b001, 0, "fill0");
        handshake(3'b010, 0, "fill1");
        handshake(3'b100, 0, "fill2");
        handshake(3'b010, 0, "fill3");
        tick(4);
        check("stall_le", 32'(le), 0);
        rails = 3'b100;
        tick(4);
        check("stall_le_held", 32'(le), 0);
        check("stall_dvalid", 32'(dvalid), 1);
        check("stall_head", 32'(dout), 0);
        dready = 1'b1;
        @(negedge clk);
        dready = 1'b0;
        check("stall_release_le", 32'(le), 1);
        @(negedge clk);
        check("stall_fifth_ack", 32'(le), 0);
        rails = 3'b000;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_valid%0d", i), 32'(dvalid), 1);
            check($sformatf("drain_word%0d", i), 32'(dout), 32'(exp_left[i]));
            dready = 1'b1;
            @(negedge clk);
            dready = 1'b0;
        end
        check("drain_empty", 32'(dvalid), 0);

        // One-cycle glitch on L[0] must not be taken as a token.
        wait_le(1'b1, "glitch_pre_le");
        rails = 3'b001;
        @(negedge clk);
        rails = 3'b000;
        tick(4);
        check("glitch_dvalid", 32'(dvalid), 0);
        check("glitch_le", 32'(le), 1);

        // Table of tokens, including multi-hot codes that set err.
        for (int i = 0; i < 8; i++) begin
            handshake(vecs[i].rails, vecs[i].hold, $sformatf("vec%0d", i));
            wait_le(1'b1, $sformatf("vec%0d_le_back", i));
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].err));
            check($sformatf("vec%0d_dvalid", i), 32'(dvalid), 32'(vecs[i].push));
            if (vecs[i].push) begin
                check($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].word));
                dready = 1'b1;
                @(negedge clk);
                dready = 1'b0;
            end
        end

        // Reset mid-handshake with two words buffered.
        handshake(3'b001, 0, "mid0");
        wait_le(1'b1, "mid1_le_hi");
        rails = 3'b100;
        wait_le(1'b0, "mid1_le_lo");
        check("mid_dvalid", 32'(dvalid), 1);
        check("mid_err_before", 32'(err), 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_le", 32'(le), 0);
        check("mid_rst_dvalid", 32'(dvalid), 0);
        check("mid_rst_err", 32'(err), 0);
        rails = 3'b000;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); check("mid_rel_le1", 32'(le), 0);
        @(negedge clk); check("mid_rel_le2", 32'(le), 0);
        @(negedge clk); check("mid_rel_le3", 32'(le), 1);
        check("mid_rel_empty", 32'(dvalid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
